inst_loader: RTL and testbench

Upstream feeder for the instruction buffer. Receives a 32-bit word stream from the host DMA path and packs every INST_BITS/32 consecutive words into one instruction. Writes each packed instruction into the instruction buffer's write port (wea/addra/din) at consecutive addresses from a programmed base address. Reports the last written address so control can program the buffer's end address.

---
 rtl/inst_loader_if.sv | 24 ++
 rtl/inst_loader.sv | 132 +++++++++++++
 tb/tb_inst_loader.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_if.sv
// Stream-in / buffer-write bundle for the instruction loader.
// The slave side is the loader itself; the master side is the host and buffer.
interface inst_loader_if #(
  parameter int ADDR_BITS = 10,
  parameter int INST_BITS = 128
);
  logic [31:0]          s_tdata;
  logic                 s_tvalid;
  logic                 s_tlast;
  logic                 s_tready;
  logic                 wea;
  logic [ADDR_BITS-1:0] addra;
  logic [INST_BITS-1:0] din;

  modport master (
    output s_tdata, s_tvalid, s_tlast,
    input  s_tready, wea, addra, din
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast,
    output s_tready, wea, addra, din
  );
endinterface

// File: rtl/inst_loader.sv
// Packs INST_BITS/32 stream words into one instruction and writes it to the
// instruction buffer at consecutive addresses from a programmed base.
module inst_loader #(
  parameter int PC_DEPTH  = 1024,
  parameter int ADDR_BITS = 10,
  parameter int INST_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset_n,
  inst_loader_if.slave         bus,
  input  logic                 load_start,
  input  logic [ADDR_BITS-1:0] base_addr,
  output logic                 busy,
  output logic                 load_done,
  output logic [ADDR_BITS-1:0] end_addr,
  output logic [ADDR_BITS:0]   inst_count,
  output logic                 err_align,
  output logic                 err_overflow
);

  localparam int WPI   = INST_BITS / 32;
  localparam int CNT_W = (WPI > 1) ? $clog2(WPI) : 1;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t               state, state_nx;
  logic [ADDR_BITS-1:0] addr_ptr;
  logic [CNT_W-1:0]     word_cnt;
  logic [INST_BITS-1:0] packed_inst;
  logic                 last_seen;

  logic last_word;
  logic at_top;

  assign last_word = (word_cnt == CNT_W'(WPI - 1));
  assign at_top    = (addr_ptr == ADDR_BITS'(PC_DEPTH - 1));
  assign bus.addra = addr_ptr;
  assign bus.din   = packed_inst;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    bus.s_tready = 1'b0;
    bus.wea      = 1'b0;
    busy         = 1'b1;
    load_done    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (load_start) state_nx = RECV;
      end
      RECV: begin
        bus.s_tready = 1'b1;
        if (bus.s_tvalid) begin
          if (last_word)        state_nx = WRITE;
          else if (bus.s_tlast) state_nx = DONE;
        end
      end
      WRITE: begin
        bus.wea  = 1'b1;
        state_nx = (last_seen || at_top) ? DONE : RECV;
      end
      DONE: begin
        load_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: the packing register is reset too, because din is visible on the
  // buffer port at all times and must read zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_ptr     <= '0;
      word_cnt     <= '0;
      packed_inst  <= '0;
      last_seen    <= 1'b0;
      end_addr     <= '0;
      inst_count   <= '0;
      err_align    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            addr_ptr     <= base_addr;
            end_addr     <= base_addr;
            word_cnt     <= '0;
            inst_count   <= '0;
            last_seen    <= 1'b0;
            err_align    <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        RECV: begin
          if (bus.s_tvalid) begin
            packed_inst[32*word_cnt +: 32] <= bus.s_tdata;
            if (last_word) begin
              last_seen <= bus.s_tlast;
              word_cnt  <= '0;
            end else if (bus.s_tlast) begin
              // A program ending mid-instruction drops the partial word group.
              err_align <= 1'b1;
              word_cnt  <= '0;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          end_addr   <= addr_ptr;
          inst_count <= inst_count + (ADDR_BITS+1)'(1);
          if (!last_seen) begin
            if (at_top) err_overflow <= 1'b1;
            else        addr_ptr     <= addr_ptr + ADDR_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a vector table for whole loads on a full-size
// instance, plus hand sequences for reset, ignored starts and a 4-deep instance.
module tb_inst_loader;
  localparam int AB = 10;
  localparam int IB = 128;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_start;
  logic [AB-1:0] base_addr;
  logic [31:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tlast;

  always #5 clk = ~clk;

  inst_loader_if #(.ADDR_BITS(AB), .INST_BITS(IB)) bus_a ();
  inst_loader_if #(.ADDR_BITS(AB), .INST_BITS(IB)) bus_b ();

  assign bus_a.s_tdata  = s_tdata;
  assign bus_a.s_tvalid = s_tvalid;
  assign bus_a.s_tlast  = s_tlast;
  assign bus_b.s_tdata  = s_tdata;
  assign bus_b.s_tvalid = s_tvalid;
  assign bus_b.s_tlast  = s_tlast;

  logic          busy_a, done_a, ealign_a, eovf_a;
  logic [AB-1:0] end_a;
  logic [AB:0]   cnt_a;
  logic          busy_b, done_b, ealign_b, eovf_b;
  logic [AB-1:0] end_b;
  logic [AB:0]   cnt_b;

  inst_loader #(.PC_DEPTH(1024), .ADDR_BITS(AB), .INST_BITS(IB)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave),
    .load_start(load_start), .base_addr(base_addr),
    .busy(busy_a), .load_done(done_a), .end_addr(end_a), .inst_count(cnt_a),
    .err_align(ealign_a), .err_overflow(eovf_a)
  );

  inst_loader #(.PC_DEPTH(4), .ADDR_BITS(AB), .INST_BITS(IB)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave),
    .load_start(load_start), .base_addr(base_addr),
    .busy(busy_b), .load_done(done_b), .end_addr(end_b), .inst_count(cnt_b),
    .err_align(ealign_b), .err_overflow(eovf_b)
  );

  typedef struct {
    logic [AB-1:0] addr;
    logic [IB-1:0] din;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [AB-1:0] base;
    logic [31:0]   first;
    int            n;
    bit            gaps;
    int            exp_acc;
    int            exp_nwr;
    logic [AB-1:0] exp_end;
    int            exp_cnt;
    bit            exp_align;
    bit            exp_ovf;
  } vec_t;

  wr_t wr_a[$];
  wr_t wr_b[$];
  int  acc_cyc[$];
  int  cyc = 0;
  int  done_cnt_a = 0, done_cyc_a = -1, overlap_a = 0;
  int  done_cnt_b = 0;
  int  pass_cnt = 0, total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_a.wea) begin
      wr_a.push_back('{addr: bus_a.addra, din: bus_a.din, cyc: cyc});
      if (bus_a.s_tready) overlap_a++;
    end
    if (bus_b.wea) wr_b.push_back('{addr: bus_b.addra, din: bus_b.din, cyc: cyc});
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (done_b) done_cnt_b++;
  end

  task automatic check(input string name, input logic [IB-1:0] act, input logic [IB-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.s_tready : bus_a.s_tready;
  endfunction

  function automatic logic [IB-1:0] pack(input logic [31:0] first, input int k);
    logic [IB-1:0] r;
    for (int j = 0; j < IB/32; j++) r[32*j +: 32] = first + 32'(4*k + j);
    return r;
  endfunction

  task automatic clear_logs();
    wr_a.delete();
    wr_b.delete();
    done_cnt_a = 0;
    done_cyc_a = -1;
    done_cnt_b = 0;
    overlap_a  = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Entered and left at posedge+1; busy must rise only after the accepting edge.
  task automatic start_load(input bit sel, input logic [AB-1:0] base);
    load_start = 1'b1;
    base_addr  = base;
    @(negedge clk);
    check("busy_before_start", sel ? busy_b : busy_a, 0);
    @(posedge clk); #1 load_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", sel ? busy_b : busy_a, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_words(input bit sel, input int n, input logic [31:0] first,
                            input bit gaps, input bit tlast_end, output int acc);
    acc = 0;
    acc_cyc.delete();
    for (int i = 0; i < n; i++) begin
      bit got = 0;
      if (gaps) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = first + 32'(i);
      s_tlast  = tlast_end && (i == n-1);
      for (int w = 0; w < 40 && !got; w++) begin
        @(negedge clk);
        if (rdy(sel)) begin
          got = 1;
          acc_cyc.push_back(cyc);
        end
        @(posedge clk); #1;
      end
      if (!got) break;
      acc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (!(sel ? busy_b : busy_a)) break;
    end
    check("idle_reached", sel ? busy_b : busy_a, 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[5];

  initial begin
    int acc;
    int exp_done;
    int ready_seen;

    vecs[0] = '{base: 10'd0,    first: 32'h0,   n: 8,  gaps: 0, exp_acc: 8,  exp_nwr: 2,
                exp_end: 10'd1,    exp_cnt: 2, exp_align: 0, exp_ovf: 0};
    vecs[1] = '{base: 10'd5,    first: 32'h0,   n: 8,  gaps: 1, exp_acc: 8,  exp_nwr: 2,
                exp_end: 10'd6,    exp_cnt: 2, exp_align: 0, exp_ovf: 0};
    vecs[2] = '{base: 10'd0,    first: 32'h100, n: 6,  gaps: 0, exp_acc: 6,  exp_nwr: 1,
                exp_end: 10'd0,    exp_cnt: 1, exp_align: 1, exp_ovf: 0};
    vecs[3] = '{base: 10'd1022, first: 32'h20,  n: 12, gaps: 0, exp_acc: 8,  exp_nwr: 2,
                exp_end: 10'd1023, exp_cnt: 2, exp_align: 0, exp_ovf: 1};
    vecs[4] = '{base: 10'd1020, first: 32'h40,  n: 16, gaps: 1, exp_acc: 16, exp_nwr: 4,
                exp_end: 10'd1023, exp_cnt: 4, exp_align: 0, exp_ovf: 0};

    reset_n    = 1'b0;
    load_start = 1'b0;
    base_addr  = '0;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    #12;
    check("rst_tready", bus_a.s_tready, 0);
    check("rst_wea",    bus_a.wea, 0);
    check("rst_busy",   busy_a, 0);
    check("rst_done",   done_a, 0);
    check("rst_addra",  bus_a.addra, 0);
    check("rst_din",    bus_a.din, 0);
    check("rst_end",    end_a, 0);
    check("rst_cnt",    cnt_a, 0);
    check("rst_errs",   {ealign_a, eovf_a}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      clear_logs();
      start_load(0, vecs[v].base);
      send_words(0, vecs[v].n, vecs[v].first, vecs[v].gaps, 1, acc);
      wait_idle(0);
      check($sformatf("v%0d_accepted", v), acc, vecs[v].exp_acc);
      check($sformatf("v%0d_nwrites", v), wr_a.size(), vecs[v].exp_nwr);
      for (int k = 0; k < wr_a.size() && k < vecs[v].exp_nwr; k++) begin
        check($sformatf("v%0d_addr%0d", v, k), wr_a[k].addr, vecs[v].base + AB'(k));
        check($sformatf("v%0d_din%0d", v, k), wr_a[k].din, pack(vecs[v].first, k));
        if (4*k+3 < acc_cyc.size())
          check($sformatf("v%0d_wea_cyc%0d", v, k), wr_a[k].cyc, acc_cyc[4*k+3] + 1);
      end
      if (v == 0 && wr_a.size() > 0)
        check("basic_din_literal", wr_a[0].din, 128'h00000003_00000002_00000001_00000000);
      check($sformatf("v%0d_end_addr", v), end_a, vecs[v].exp_end);
      check($sformatf("v%0d_inst_count", v), cnt_a, vecs[v].exp_cnt);
      check($sformatf("v%0d_err_align", v), ealign_a, vecs[v].exp_align);
      check($sformatf("v%0d_err_overflow", v), eovf_a, vecs[v].exp_ovf);
      check($sformatf("v%0d_done_pulses", v), done_cnt_a, 1);
      exp_done = -1;
      if (vecs[v].exp_align && acc_cyc.size() > 0) exp_done = acc_cyc[acc_cyc.size()-1] + 1;
      else if (!vecs[v].exp_align && wr_a.size() > 0) exp_done = wr_a[wr_a.size()-1].cyc + 1;
      check($sformatf("v%0d_done_cyc", v), done_cyc_a, exp_done);
      check($sformatf("v%0d_ready_in_write", v), overlap_a, 0);
    end

    // load_start with base 9 in the middle of a load from base 0
    clear_logs();
    start_load(0, 10'd0);
    fork
      send_words(0, 8, 32'h200, 0, 1, acc);
      begin
        repeat (3) @(posedge clk);
        #1 load_start = 1'b1;
        base_addr = 10'd9;
        @(posedge clk); #1 load_start = 1'b0;
      end
    join
    wait_idle(0);
    check("ign_nwrites", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      check("ign_addr0", wr_a[0].addr, 0);
      check("ign_addr1", wr_a[1].addr, 1);
      check("ign_din1",  wr_a[1].din, pack(32'h200, 1));
    end
    check("ign_end", end_a, 1);

    // load_start during the DONE cycle of an overflowed load must not clear flags
    clear_logs();
    start_load(0, 10'd1022);
    fork
      send_words(0, 12, 32'h300, 0, 1, acc);
      begin
        for (int w = 0; w < 100; w++) begin
          @(negedge clk);
          if (bus_a.wea && bus_a.addra == 10'd1023) break;
        end
        @(posedge clk); #1 load_start = 1'b1;
        base_addr = 10'd9;
        @(posedge clk); #1 load_start = 1'b0;
      end
    join
    wait_idle(0);
    check("ign_done_ovf_kept", eovf_a, 1);
    check("ign_done_end",      end_a, 1023);
    check("ign_done_pulses",   done_cnt_a, 1);
    check("ign_done_nwrites",  wr_a.size(), 2);

    // asynchronous reset after two of four words
    do_reset();
    start_load(0, 10'd0);
    send_words(0, 2, 32'h50, 0, 0, acc);
    clear_logs();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy",   busy_a, 0);
    check("arst_tready", bus_a.s_tready, 0);
    check("arst_wea",    bus_a.wea, 0);
    check("arst_din",    bus_a.din, 0);
    check("arst_addra",  bus_a.addra, 0);
    check("arst_state",  {done_a, ealign_a, eovf_a, end_a, cnt_a}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_wea", wr_a.size(), 0);
    clear_logs();
    start_load(0, 10'd0);
    send_words(0, 4, 32'h60, 0, 1, acc);
    wait_idle(0);
    check("arst_reload_nwr", wr_a.size(), 1);
    if (wr_a.size() == 1) begin
      check("arst_reload_addr", wr_a[0].addr, 0);
      check("arst_reload_din",  wr_a[0].din, 128'h00000063_00000062_00000061_00000060);
    end

    // 4-deep instance: base 2, three instructions' worth of words
    do_reset();
    clear_logs();
    start_load(1, 10'd2);
    send_words(1, 12, 32'h700, 0, 1, acc);
    wait_idle(1);
    check("ovf_accepted", acc, 8);
    check("ovf_nwrites",  wr_b.size(), 2);
    if (wr_b.size() == 2) begin
      check("ovf_addr0", wr_b[0].addr, 2);
      check("ovf_addr1", wr_b[1].addr, 3);
      check("ovf_din1",  wr_b[1].din, pack(32'h700, 1));
    end
    check("ovf_flag",  eovf_b, 1);
    check("ovf_align", ealign_b, 0);
    check("ovf_end",   end_b, 3);
    check("ovf_cnt",   cnt_b, 2);
    check("ovf_done",  done_cnt_b, 1);
    s_tvalid   = 1'b1;
    ready_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy(1)) ready_seen++;
    end
    s_tvalid = 1'b0;
    check("ovf_ready_after_done", ready_seen, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
